id_ex_hazard_stage: RTL and testbench

ID/EX pipeline register combined with the hazard/forwarding control of the 5-stage RV32I pipeline. Registers decode-stage operands and control into EX. Generates the 2-bit operand-select codes that drive the two EX-stage 3:1 forwarding muxes (00 = register file, 01 = WB result, 10 = MEM ALU result). Also detects load-use and branch hazards and issues stall/flush to the IF/ID stages.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fwd_sel.sv | 29 ++
 rtl/id_ex_hazard_stage.sv | 120 ++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: forwarding-mux selects,
// result-source codes and default datapath widths.
package riscv_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REGA_W_DEFAULT = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select for one EX-stage 3:1 operand mux.
// MEM wins over WB because it holds the younger write to the same register.
module fwd_sel
    import riscv_pkg::*;
#(
    parameter int REGA_W = REGA_W_DEFAULT
) (
    input  logic [REGA_W-1:0] rs_e,
    input  logic [REGA_W-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REGA_W-1:0] rd_w,
    input  logic              reg_write_w,
    output logic [1:0]        sel
);

    logic rs_nonzero;

    assign rs_nonzero = (rs_e != '0);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m == rs_e) && rs_nonzero) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w == rs_e) && rs_nonzero) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register plus load-use/branch hazard control and the
// operand forwarding selects for the EX stage.
module id_ex_hazard_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REGA_W = REGA_W_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REGA_W-1:0] rs1_d,
    input  logic [REGA_W-1:0] rs2_d,
    input  logic [REGA_W-1:0] rd_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic              reg_write_d,
    input  logic              mem_write_d,
    input  logic              jump_d,
    input  logic              branch_d,
    input  logic              alu_src_d,
    input  logic [1:0]        result_src_d,
    input  logic [2:0]        alu_control_d,
    input  logic              valid_d,
    input  logic [REGA_W-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REGA_W-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              pc_src_e,
    output logic [REGA_W-1:0] rs1_e,
    output logic [REGA_W-1:0] rs2_e,
    output logic [REGA_W-1:0] rd_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic              reg_write_e,
    output logic              mem_write_e,
    output logic              jump_e,
    output logic              branch_e,
    output logic              alu_src_e,
    output logic [1:0]        result_src_e,
    output logic [2:0]        alu_control_e,
    output logic              valid_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  lw_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int EX_W = 3 * REGA_W + 5 * XLEN + 5 + 2 + 3 + 1;

    logic [EX_W-1:0]  ex_d, ex_q;
    logic [CNT_W-1:0] lw_cnt_d, lw_cnt_q;
    logic [CNT_W-1:0] fl_cnt_d, fl_cnt_q;
    logic             lw_stall;

    // A flushed EX slot is all-zero, so valid/reg_write/mem_write/rd drop together.
    assign ex_d = flush_e ? '0 :
        {rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
         reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d,
         result_src_d, alu_control_d, valid_d};

    assign {rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
            reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
            result_src_e, alu_control_e, valid_e} = ex_q;

    assign lw_stall = (result_src_e == RES_LOAD) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    assign stall_f = lw_stall;
    assign stall_d = lw_stall;
    assign flush_d = pc_src_e;
    assign flush_e = lw_stall | pc_src_e;

    assign lw_cnt_d = (lw_stall && (lw_cnt_q != '1)) ? lw_cnt_q + CNT_W'(1) : lw_cnt_q;
    assign fl_cnt_d = (pc_src_e && (fl_cnt_q != '1)) ? fl_cnt_q + CNT_W'(1) : fl_cnt_q;

    assign lw_stall_cnt = lw_cnt_q;
    assign flush_cnt    = fl_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= '0;
            lw_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            ex_q     <= ex_d;
            lw_cnt_q <= lw_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    fwd_sel #(.REGA_W(REGA_W)) u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel         (forward_a_e)
    );

    fwd_sel #(.REGA_W(REGA_W)) u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .sel         (forward_b_e)
    );

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for the ID/EX register, forwarding selects and hazard control.
// Counters are built 4 bits wide here so saturation is reachable in a short run.
module tb_id_ex_hazard_stage;

    localparam int XLEN   = 32;
    localparam int REGA_W = 5;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk, rst;
    logic [REGA_W-1:0] rs1_d, rs2_d, rd_d, rd_m, rd_w;
    logic [XLEN-1:0]   rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
    logic              reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d, valid_d;
    logic [1:0]        result_src_d;
    logic [2:0]        alu_control_d;
    logic              reg_write_m, reg_write_w, pc_src_e;
    logic [REGA_W-1:0] rs1_e, rs2_e, rd_e;
    logic [XLEN-1:0]   rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic              reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, valid_e;
    logic [1:0]        result_src_e;
    logic [2:0]        alu_control_e;
    logic [1:0]        forward_a_e, forward_b_e;
    logic              stall_f, stall_d, flush_d, flush_e;
    logic [CNT_W-1:0]  lw_stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_lw, exp_fl;

    id_ex_hazard_stage #(.XLEN(XLEN), .REGA_W(REGA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
        .branch_d(branch_d), .alu_src_d(alu_src_d), .result_src_d(result_src_d),
        .alu_control_d(alu_control_d), .valid_d(valid_d),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
        .branch_e(branch_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e),
        .alu_control_e(alu_control_e), .valid_e(valid_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .lw_stall_cnt(lw_stall_cnt), .flush_cnt(flush_cnt)
    );

    // Clock: posedge at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rd_d = '0;
        rd1_d = '0; rd2_d = '0; imm_ext_d = '0; pc_d = '0; pc_plus4_d = '0;
        reg_write_d = 0; mem_write_d = 0; jump_d = 0; branch_d = 0; alu_src_d = 0;
        result_src_d = 2'b00; alu_control_d = 3'b000; valid_d = 0;
        rd_m = '0; reg_write_m = 0; rd_w = '0; reg_write_w = 0; pc_src_e = 0;
    endtask

    task automatic drive_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [1:0] res_src, input logic [31:0] pc);
        rs1_d = rs1; rs2_d = rs2; rd_d = rd; result_src_d = res_src;
        reg_write_d = 1; valid_d = 1; pc_d = pc; pc_plus4_d = pc + 32'd4;
    endtask

    task automatic test_reset();
        clear_inputs();
        drive_id(5'd1, 5'd2, 5'd3, 2'b00, 32'h100);
        pc_src_e = 1;
        tick();
        pc_src_e = 0;
        tick();
        total++; if (flush_cnt !== 4'd1) begin bad++; $display("FAIL pre_reset_flush_cnt got=%0d want=1", flush_cnt); end
        total++; if (valid_e !== 1'b1) begin bad++; $display("FAIL pre_reset_valid_e got=%0b want=1", valid_e); end
        #2;
        rst = 1;
        #1;
        total++; if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || rd_e !== 5'd0 || pc_e !== 32'd0 || rs1_e !== 5'd0)
            begin bad++; $display("FAIL reset_ex_regs got valid=%0b rw=%0b rd=%0d pc=%h rs1=%0d want all 0", valid_e, reg_write_e, rd_e, pc_e, rs1_e); end
        total++; if (flush_cnt !== 4'd0 || lw_stall_cnt !== 4'd0)
            begin bad++; $display("FAIL reset_counters got fl=%0d lw=%0d want 0 0", flush_cnt, lw_stall_cnt); end
        total++; if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00 || stall_f !== 1'b0 || stall_d !== 1'b0 || flush_e !== 1'b0 || flush_d !== 1'b0)
            begin bad++; $display("FAIL reset_controls got fa=%b fb=%b sf=%b sd=%b fe=%b fd=%b want all 0", forward_a_e, forward_b_e, stall_f, stall_d, flush_e, flush_d); end
        pc_src_e = 1;
        #1;
        total++; if (flush_d !== 1'b1) begin bad++; $display("FAIL reset_flush_d_follows got=%0b want=1", flush_d); end
        pc_src_e = 0;
        #1;
        rst = 0;
        exp_lw = '0;
        exp_fl = '0;
        clear_inputs();
        tick();
    endtask

    task automatic test_passthrough();
        clear_inputs();
        drive_id(5'd11, 5'd12, 5'd13, 2'b10, 32'h2000);
        rd1_d = 32'hdead_beef; rd2_d = 32'h1234_5678; imm_ext_d = 32'hffff_fff0;
        mem_write_d = 1; jump_d = 1; branch_d = 0; alu_src_d = 1; alu_control_d = 3'b101;
        tick();
        total++; if (rs1_e !== 5'd11 || rs2_e !== 5'd12 || rd_e !== 5'd13 || result_src_e !== 2'b10)
            begin bad++; $display("FAIL pass_addr got rs1=%0d rs2=%0d rd=%0d rs=%b want 11 12 13 10", rs1_e, rs2_e, rd_e, result_src_e); end
        total++; if (rd1_e !== 32'hdead_beef || rd2_e !== 32'h1234_5678 || imm_ext_e !== 32'hffff_fff0 || pc_e !== 32'h2000 || pc_plus4_e !== 32'h2004)
            begin bad++; $display("FAIL pass_data got rd1=%h rd2=%h imm=%h pc=%h pc4=%h", rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e); end
        total++; if (mem_write_e !== 1'b1 || jump_e !== 1'b1 || branch_e !== 1'b0 || alu_src_e !== 1'b1 || alu_control_e !== 3'b101 || valid_e !== 1'b1 || reg_write_e !== 1'b1)
            begin bad++; $display("FAIL pass_ctrl got mw=%b j=%b b=%b as=%b ac=%b v=%b rw=%b", mem_write_e, jump_e, branch_e, alu_src_e, alu_control_e, valid_e, reg_write_e); end
        // back-to-back: next instruction replaces the first one cycle later
        drive_id(5'd14, 5'd15, 5'd16, 2'b00, 32'h2004);
        mem_write_d = 0; jump_d = 0; branch_d = 1; alu_control_d = 3'b010;
        tick();
        total++; if (rs1_e !== 5'd14 || rd_e !== 5'd16 || pc_e !== 32'h2004 || branch_e !== 1'b1 || jump_e !== 1'b0 || alu_control_e !== 3'b010)
            begin bad++; $display("FAIL back_to_back got rs1=%0d rd=%0d pc=%h b=%b j=%b ac=%b", rs1_e, rd_e, pc_e, branch_e, jump_e, alu_control_e); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        drive_id(5'd5, 5'd6, 5'd5, 2'b00, 32'h300);
        tick();
        clear_inputs();
        reg_write_m = 1; rd_m = 5'd5; reg_write_w = 1; rd_w = 5'd5;
        #1;
        total++; if (forward_a_e !== 2'b10) begin bad++; $display("FAIL fwd_a_mem_priority got=%b want=10", forward_a_e); end
        total++; if (forward_b_e !== 2'b00) begin bad++; $display("FAIL fwd_b_nomatch got=%b want=00", forward_b_e); end
        reg_write_m = 0;
        #1;
        total++; if (forward_a_e !== 2'b01) begin bad++; $display("FAIL fwd_a_wb got=%b want=01", forward_a_e); end
        reg_write_m = 1; rd_m = 5'd6; rd_w = 5'd6; reg_write_w = 1;
        #1;
        total++; if (forward_a_e !== 2'b00 || forward_b_e !== 2'b10) begin bad++; $display("FAIL fwd_b_mem got a=%b b=%b want 00 10", forward_a_e, forward_b_e); end
        rd_m = 5'd5;
        #1;
        total++; if (forward_a_e !== 2'b10 || forward_b_e !== 2'b01) begin bad++; $display("FAIL fwd_split got a=%b b=%b want 10 01", forward_a_e, forward_b_e); end
        reg_write_w = 0; rd_m = 5'd6; reg_write_m = 0;
        #1;
        total++; if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin bad++; $display("FAIL fwd_no_write got a=%b b=%b want 00 00", forward_a_e, forward_b_e); end
    endtask

    task automatic test_x0();
        clear_inputs();
        drive_id(5'd0, 5'd0, 5'd4, 2'b00, 32'h400);
        tick();
        clear_inputs();
        reg_write_m = 1; rd_m = 5'd0; reg_write_w = 1; rd_w = 5'd0;
        #1;
        total++; if (forward_a_e !== 2'b00 || forward_b_e !== 2'b00) begin bad++; $display("FAIL x0_no_forward got a=%b b=%b want 00 00", forward_a_e, forward_b_e); end
        // lw x0 followed by a reader of x0 must not stall
        clear_inputs();
        drive_id(5'd1, 5'd2, 5'd0, 2'b01, 32'h404);
        tick();
        drive_id(5'd0, 5'd0, 5'd3, 2'b00, 32'h408);
        #1;
        total++; if (stall_f !== 1'b0 || flush_e !== 1'b0) begin bad++; $display("FAIL x0_no_stall got sf=%b fe=%b want 0 0", stall_f, flush_e); end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        drive_id(5'd1, 5'd2, 5'd7, 2'b01, 32'h500);
        tick();
        drive_id(5'd8, 5'd9, 5'd10, 2'b00, 32'h504);
        #1;
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL lw_independent got sf=%b want 0", stall_f); end
        rs1_d = 5'd7;
        #1;
        total++; if (stall_f !== 1'b1 || stall_d !== 1'b1 || flush_e !== 1'b1 || flush_d !== 1'b0)
            begin bad++; $display("FAIL lw_stall_ctrl got sf=%b sd=%b fe=%b fd=%b want 1 1 1 0", stall_f, stall_d, flush_e, flush_d); end
        tick();
        exp_lw = exp_lw + 4'd1;
        total++; if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || rd_e !== 5'd0 || result_src_e !== 2'b00)
            begin bad++; $display("FAIL lw_bubble got v=%b rw=%b rd=%0d rs=%b want 0 0 0 00", valid_e, reg_write_e, rd_e, result_src_e); end
        total++; if (lw_stall_cnt !== exp_lw) begin bad++; $display("FAIL lw_cnt got=%0d want=%0d", lw_stall_cnt, exp_lw); end
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL lw_stall_release got=%b want 0", stall_f); end
        tick();
        total++; if (valid_e !== 1'b1 || rs1_e !== 5'd7 || pc_e !== 32'h504) begin bad++; $display("FAIL lw_replay got v=%b rs1=%0d pc=%h", valid_e, rs1_e, pc_e); end
    endtask

    task automatic test_branch_flush();
        clear_inputs();
        drive_id(5'd3, 5'd4, 5'd5, 2'b00, 32'h600);
        pc_src_e = 1;
        #1;
        total++; if (flush_d !== 1'b1 || flush_e !== 1'b1 || stall_f !== 1'b0 || stall_d !== 1'b0)
            begin bad++; $display("FAIL br_ctrl got fd=%b fe=%b sf=%b sd=%b want 1 1 0 0", flush_d, flush_e, stall_f, stall_d); end
        tick();
        pc_src_e = 0;
        exp_fl = exp_fl + 4'd1;
        total++; if (valid_e !== 1'b0 || pc_e !== 32'd0 || reg_write_e !== 1'b0) begin bad++; $display("FAIL br_bubble got v=%b pc=%h rw=%b", valid_e, pc_e, reg_write_e); end
        total++; if (flush_cnt !== exp_fl) begin bad++; $display("FAIL br_cnt got=%0d want=%0d", flush_cnt, exp_fl); end
        tick();
        total++; if (flush_cnt !== exp_fl || valid_e !== 1'b1) begin bad++; $display("FAIL br_after got cnt=%0d v=%b want %0d 1", flush_cnt, valid_e, exp_fl); end
    endtask

    task automatic test_simultaneous();
        clear_inputs();
        drive_id(5'd1, 5'd2, 5'd9, 2'b01, 32'h700);
        tick();
        drive_id(5'd3, 5'd9, 5'd4, 2'b00, 32'h704);
        pc_src_e = 1;
        #1;
        total++; if (stall_f !== 1'b1 || stall_d !== 1'b1 || flush_d !== 1'b1 || flush_e !== 1'b1)
            begin bad++; $display("FAIL both_ctrl got sf=%b sd=%b fd=%b fe=%b want 1 1 1 1", stall_f, stall_d, flush_d, flush_e); end
        tick();
        pc_src_e = 0;
        exp_lw = exp_lw + 4'd1;
        exp_fl = exp_fl + 4'd1;
        total++; if (valid_e !== 1'b0 || reg_write_e !== 1'b0) begin bad++; $display("FAIL both_bubble got v=%b rw=%b", valid_e, reg_write_e); end
        total++; if (lw_stall_cnt !== exp_lw || flush_cnt !== exp_fl)
            begin bad++; $display("FAIL both_cnt got lw=%0d fl=%0d want %0d %0d", lw_stall_cnt, flush_cnt, exp_lw, exp_fl); end
    endtask

    task automatic test_saturation();
        clear_inputs();
        pc_src_e = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_fl = (exp_fl == CNT_MAX) ? CNT_MAX : exp_fl + 4'd1;
        end
        pc_src_e = 0;
        total++; if (flush_cnt !== 4'hF || flush_cnt !== exp_fl) begin bad++; $display("FAIL fl_saturate got=%0d want=15", flush_cnt); end
        for (int i = 0; i < 20; i++) begin
            drive_id(5'd1, 5'd2, 5'd7, 2'b01, 32'h800);
            tick();
            drive_id(5'd7, 5'd2, 5'd8, 2'b00, 32'h804);
            tick();
            exp_lw = (exp_lw == CNT_MAX) ? CNT_MAX : exp_lw + 4'd1;
        end
        total++; if (lw_stall_cnt !== 4'hF || lw_stall_cnt !== exp_lw) begin bad++; $display("FAIL lw_saturate got=%0d want=15", lw_stall_cnt); end
        clear_inputs();
        tick();
        total++; if (flush_cnt !== 4'hF || lw_stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_hold got fl=%0d lw=%0d want 15 15", flush_cnt, lw_stall_cnt); end
    endtask

    initial begin
        clear_inputs();
        exp_lw = '0;
        exp_fl = '0;
        rst = 1;
        #12;
        rst = 0;
        tick();
        test_reset();
        test_passthrough();
        test_forwarding();
        test_x0();
        test_load_use();
        test_branch_flush();
        test_simultaneous();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
